data_collector_arb: RTL and testbench

Multi-channel successor to the single-FIFO data collector. It drains NUM_CH upstream pp_wr_fifo instances of RAH packets and merges them into one write stream to the peripheral group controller.
- Channel selection: round-robin arbitration with bounded bursts.
- Upstream safety: reads are underrun-safe against each FIFO's almost-empty flag.
- Downstream safety: reads are throttled by the downstream almost-full flag.

---
 rtl/data_collector_arb.sv | 134 +++++++++++++
 tb/tb_data_collector_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_collector_arb.sv
// Round-robin collector that drains NUM_CH read-latency-1 FIFOs into one downstream write stream.
// Optional source-channel tag on the output (wr_ch) is enabled with DATA_COLLECTOR_CH_TAG_EN.
module data_collector_arb #(
   parameter int RAH_PACKET_WIDTH = 48,
   parameter int NUM_CH = 4,
   parameter int BURST_MAX = 8,
   localparam int CH_ID_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_CH*RAH_PACKET_WIDTH-1:0] fifo_read_data,
   input  logic [NUM_CH-1:0]                  f_empty,
   input  logic [NUM_CH-1:0]                  f_a_empty,
   output logic [NUM_CH-1:0]                  fifo_read_en,
   input  logic                               out_a_full,
   output logic [RAH_PACKET_WIDTH-1:0]        fifo_write_data,
   output logic                               wr_en
`ifdef DATA_COLLECTOR_CH_TAG_EN
   ,
   output logic [CH_ID_WIDTH-1:0]             wr_ch
`endif
);

   typedef enum logic {IDLE, READ} state_t;

   state_t                        state_q, state_d;
   logic [CH_ID_WIDTH-1:0]        grant_q, grant_d;
   logic [CH_ID_WIDTH-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CH_ID_WIDTH-1:0]        rd_ch_q, rd_ch_d;
   logic [7:0]                    burst_cnt_q, burst_cnt_d;
   logic [NUM_CH-1:0]             rd_en_q, rd_en_d;
   logic                          rd_v_q, rd_v_d;
   logic                          wr_en_q, wr_en_d;
   logic [RAH_PACKET_WIDTH-1:0]   data_q, data_d;
   logic                          can_read;
   logic                          found;
   int                            idx;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      rd_en_d     = '0;
      can_read    = 1'b0;
      found       = 1'b0;
      idx         = 0;
      // Data for the read strobed this cycle arrives next cycle; remember its source.
      rd_v_d      = |rd_en_q;
      rd_ch_d     = grant_q;
      wr_en_d     = rd_v_q;
      data_d      = rd_v_q ? fifo_read_data[int'(rd_ch_q)*RAH_PACKET_WIDTH +: RAH_PACKET_WIDTH]
                           : data_q;
      case (state_q)
         IDLE: begin
            if (!out_a_full) begin
               for (int k = 0; k < NUM_CH; k++) begin
                  idx = (int'(rr_ptr_q) + k) % NUM_CH;
                  if (!found && !f_empty[idx]) begin
                     found   = 1'b1;
                     grant_d = CH_ID_WIDTH'(idx);
                  end
               end
            end
            if (found) begin
               burst_cnt_d = '0;
               state_d     = READ;
            end
         end
         READ: begin
            // A read strobed this cycle has not popped yet, so one entry left means none to spare.
            can_read = !f_empty[grant_q]
                       && !(f_a_empty[grant_q] && rd_en_q[grant_q])
                       && !out_a_full
                       && (burst_cnt_q < 8'(BURST_MAX));
            if (can_read) begin
               rd_en_d[grant_q] = 1'b1;
               burst_cnt_d      = burst_cnt_q + 8'd1;
            end else begin
               rr_ptr_d = CH_ID_WIDTH'((int'(grant_q) + 1) % NUM_CH);
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         rd_ch_q     <= '0;
         burst_cnt_q <= '0;
         rd_en_q     <= '0;
         rd_v_q      <= 1'b0;
         wr_en_q     <= 1'b0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         rd_ch_q     <= rd_ch_d;
         burst_cnt_q <= burst_cnt_d;
         rd_en_q     <= rd_en_d;
         rd_v_q      <= rd_v_d;
         wr_en_q     <= wr_en_d;
         data_q      <= data_d;
      end
   end

   assign fifo_read_en    = rd_en_q;
   assign wr_en           = wr_en_q;
   assign fifo_write_data = data_q;

`ifdef DATA_COLLECTOR_CH_TAG_EN
   logic [CH_ID_WIDTH-1:0] wr_ch_q, wr_ch_d;

   always_comb begin
      wr_ch_d = rd_v_q ? rd_ch_q : wr_ch_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ch_q <= '0;
      end else begin
         wr_ch_q <= wr_ch_d;
      end
   end

   assign wr_ch = wr_ch_q;
`endif

endmodule

// File: tb/tb_data_collector_arb.sv
// Directed bench for data_collector_arb: FIFO models on each channel, write log, hand-computed expectations.
module tb_data_collector_arb;
   localparam int W  = 48;
   localparam int NC = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [NC*W-1:0] rdata_flat;
   logic [NC-1:0]   f_empty, f_a_empty, fifo_read_en;
   logic            out_a_full;
   logic [W-1:0]    fifo_write_data;
   logic            wr_en;
`ifdef DATA_COLLECTOR_CH_TAG_EN
   logic [1:0]      wr_ch;
`endif

   data_collector_arb #(.RAH_PACKET_WIDTH(W), .NUM_CH(NC), .BURST_MAX(8)) dut (
      .clk(clk), .rst(rst), .fifo_read_data(rdata_flat), .f_empty(f_empty),
      .f_a_empty(f_a_empty), .fifo_read_en(fifo_read_en), .out_a_full(out_a_full),
      .fifo_write_data(fifo_write_data), .wr_en(wr_en)
`ifdef DATA_COLLECTOR_CH_TAG_EN
      , .wr_ch(wr_ch)
`endif
   );

   always #5 clk = ~clk;

   // Upstream FIFO models: pointers written by push (initial) and pop (always) respectively.
   logic [W-1:0] mem [NC][64];
   logic [5:0]   wp [NC];
   logic [5:0]   rp [NC];
   int           underrun = 0;
   int           cyc = 0;

   initial begin
      for (int i = 0; i < NC; i++) wp[i] = '0;
   end
   initial begin
      for (int i = 0; i < NC; i++) rp[i] = '0;
      rdata_flat = '0;
   end

   always_comb begin
      for (int i = 0; i < NC; i++) begin
         f_empty[i]   = (6'(wp[i] - rp[i]) == 6'd0);
         f_a_empty[i] = (6'(wp[i] - rp[i]) <= 6'd1);
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NC; i++) begin
         if (fifo_read_en[i]) begin
            if (wp[i] == rp[i]) underrun <= underrun + 1;
            rdata_flat[i*W +: W] <= mem[i][rp[i]];
            rp[i] <= rp[i] + 6'd1;
         end
      end
   end

   // Write log captured mid-cycle.
   logic [W-1:0] log_data [256];
   int           log_cyc  [256];
   int           log_ch   [256];
   int           n_wr = 0;

   always @(negedge clk) begin
      if (wr_en) begin
         log_data[n_wr] <= fifo_write_data;
         log_cyc[n_wr]  <= cyc;
`ifdef DATA_COLLECTOR_CH_TAG_EN
         log_ch[n_wr]   <= int'(wr_ch);
`else
         log_ch[n_wr]   <= 0;
`endif
         n_wr <= n_wr + 1;
      end
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] pkt(input int ch, input int seq);
      return {16'hA5C0, 8'(ch), 16'h0000, 8'(seq)};
   endfunction

   task automatic push(input int ch, input int seq);
      mem[ch][wp[ch]] = pkt(ch, seq);
      wp[ch] = wp[ch] + 6'd1;
   endtask

   task automatic wait_rd(input string tag, input int ch, input int n);
      int cnt = 0;
      int t   = 0;
      while (cnt < n && t < 100) begin
         @(negedge clk);
         t++;
         if (fifo_read_en[ch]) cnt++;
      end
      check(tag, 64'(cnt), 64'(n));
   endtask

   task automatic wait_wr(input string tag, input int target);
      int t = 0;
      while (n_wr < target && t < 400) begin
         @(negedge clk);
         t++;
      end
      check(tag, 64'(n_wr >= target), 64'd1);
   endtask

   int t2_ch  [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 1, 1};
   int t2_seq [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 8, 9};
   int t5_ch  [4]  = '{0, 1, 1, 1};
   int t5_seq [4]  = '{50, 1, 2, 3};

   initial begin
      int base, rd_cnt, wr_cnt;
      rst        = 1'b1;
      out_a_full = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rd_en", 64'(fifo_read_en), 64'd0);
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_data", 64'(fifo_write_data), 64'd0);
`ifdef DATA_COLLECTOR_CH_TAG_EN
      check("rst_wr_ch", 64'(wr_ch), 64'd0);
`endif

      // Test 1: ch0 holds A1..A3; reads at cycles 2..4, writes at 4..6 after release.
      for (int s = 1; s <= 3; s++) push(0, s);
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("t1_rd_k%0d", k), 64'(fifo_read_en), (k >= 2 && k <= 4) ? 64'd1 : 64'd0);
         check($sformatf("t1_wr_k%0d", k), 64'(wr_en), (k >= 4 && k <= 6) ? 64'd1 : 64'd0);
         if (k >= 4 && k <= 6) begin
            check($sformatf("t1_data_k%0d", k), 64'(fifo_write_data), 64'(pkt(0, k - 3)));
`ifdef DATA_COLLECTOR_CH_TAG_EN
            check($sformatf("t1_ch_k%0d", k), 64'(wr_ch), 64'd0);
`endif
         end
      end
      check("t1_hold", 64'(fifo_write_data), 64'(pkt(0, 3)));

      // Test 2: ch1=10, ch2=2 -> 8 x ch1, 2 x ch2, 2 x ch1 with idle gaps.
      base = n_wr;
      for (int s = 0; s < 10; s++) push(1, s);
      push(2, 0);
      push(2, 1);
      wait_wr("t2_wait", base + 12);
      repeat (4) @(negedge clk);
      check("t2_count", 64'(n_wr - base), 64'd12);
      for (int i = 0; i < 12; i++) begin
         check($sformatf("t2_pkt%0d", i), 64'(log_data[base + i]), 64'(pkt(t2_ch[i], t2_seq[i])));
`ifdef DATA_COLLECTOR_CH_TAG_EN
         check($sformatf("t2_ch%0d", i), 64'(log_ch[base + i]), 64'(t2_ch[i]));
`endif
      end
      check("t2_b2b", 64'(log_cyc[base + 7] - log_cyc[base]), 64'd7);
      check("t2_gap12", 64'(log_cyc[base + 8] - log_cyc[base + 7]), 64'd3);
      check("t2_gap21", 64'(log_cyc[base + 10] - log_cyc[base + 9]), 64'd3);
      check("t2_underrun", 64'(underrun), 64'd0);

      // Test 3: ch3 with exactly one entry, then a refill.
      base   = n_wr;
      rd_cnt = 0;
      push(3, 0);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (fifo_read_en[3]) rd_cnt++;
      end
      check("t3_single_rd", 64'(rd_cnt), 64'd1);
      push(3, 1);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (fifo_read_en[3]) rd_cnt++;
      end
      check("t3_refill_rd", 64'(rd_cnt), 64'd2);
      check("t3_count", 64'(n_wr - base), 64'd2);
      check("t3_pkt0", 64'(log_data[base]), 64'(pkt(3, 0)));
      check("t3_pkt1", 64'(log_data[base + 1]), 64'(pkt(3, 1)));
      check("t3_underrun", 64'(underrun), 64'd0);

      // Test 4: out_a_full raised after the 3rd read of a 20-packet ch0 backlog.
      base = n_wr;
      for (int s = 0; s < 20; s++) push(0, s);
      wait_rd("t4_wait_rd", 0, 3);
      out_a_full = 1'b1;
      @(negedge clk);
      check("t4_rd_drop", 64'(fifo_read_en[0]), 64'd0);
      wr_cnt = 0;
      rd_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (wr_en) wr_cnt++;
         if (|fifo_read_en) rd_cnt++;
         @(negedge clk);
      end
      check("t4_inflight_wr", 64'(wr_cnt), 64'd2);
      check("t4_no_rd_full", 64'(rd_cnt), 64'd0);
      out_a_full = 1'b0;
      wait_wr("t4_wait", base + 20);
      repeat (4) @(negedge clk);
      check("t4_count", 64'(n_wr - base), 64'd20);
      for (int i = 0; i < 20; i++)
         check($sformatf("t4_pkt%0d", i), 64'(log_data[base + i]), 64'(pkt(0, i)));
      check("t4_underrun", 64'(underrun), 64'd0);

      // Test 5: reset while the first ch1 read is in flight; ch0 then wins from rr_ptr=0.
      for (int s = 0; s < 4; s++) push(1, s);
      wait_rd("t5_wait_rd", 1, 1);
      base = n_wr;
      rst  = 1'b1;
      push(0, 50);
      @(negedge clk);
      check("t5_rst_wr_en", 64'(wr_en), 64'd0);
      check("t5_rst_rd_en", 64'(fifo_read_en), 64'd0);
      check("t5_rst_data", 64'(fifo_write_data), 64'd0);
`ifdef DATA_COLLECTOR_CH_TAG_EN
      check("t5_rst_wr_ch", 64'(wr_ch), 64'd0);
`endif
      rst = 1'b0;
      wait_wr("t5_wait", base + 4);
      repeat (6) @(negedge clk);
      check("t5_count", 64'(n_wr - base), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t5_pkt%0d", i), 64'(log_data[base + i]), 64'(pkt(t5_ch[i], t5_seq[i])));
`ifdef DATA_COLLECTOR_CH_TAG_EN
         check($sformatf("t5_ch%0d", i), 64'(log_ch[base + i]), 64'(t5_ch[i]));
`endif
      end
      check("t5_underrun", 64'(underrun), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
